// File: rtl/adder_seq_pkg_amisha.sv
// Shared definitions for the slice-serial adder sequencer.
// Holds the controller state encoding and the helper that sizes the slice index.
package adder_seq_pkg_amisha;

  // 2'b11 is unused and is steered back to IDLE by the controller.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADD  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Width of the slice index: clog2(k), never less than one bit.
  function automatic int idx_width(input int k);
    if (k <= 2) begin
      return 1;
    end else begin
      return $clog2(k);
    end
  endfunction

endpackage

// File: rtl/adder_slice_cin_amisha.sv
// N-bit combinational adder slice with carry-in and carry-out.
// Ports: a_i/b_i slice operands, cin_i carry-in, sum_o slice sum, cout_o carry-out.
module adder_slice_cin_amisha #(
  parameter int N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  // Operands are zero-extended by one bit so the top bit of the result is the carry-out.
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin_i};

endmodule

// File: rtl/adder_seq_ctrl_amisha.sv
// Slice-serial W-bit adder: one shared N-bit slice adds one slice per clock,
// LSB first, with the inter-slice carry held in a register.
// Ports:
//   clk_amisha, rst_n_amisha   clock and asynchronous active-low reset
//   start_amisha               request; accepted only while ready_amisha=1
//   a_amisha, b_amisha, cin_amisha  operands, captured on an accepted start
//   ready_amisha / busy_amisha / done_amisha  handshake and status
//   sum_amisha, cout_amisha    result, stable from done until the next accepted start
module adder_seq_ctrl_amisha
  import adder_seq_pkg_amisha::*;
#(
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic           clk_amisha,
  input  logic           rst_n_amisha,
  input  logic           start_amisha,
  input  logic [N*K-1:0] a_amisha,
  input  logic [N*K-1:0] b_amisha,
  input  logic           cin_amisha,
  output logic           ready_amisha,
  output logic           busy_amisha,
  output logic           done_amisha,
  output logic [N*K-1:0] sum_amisha,
  output logic           cout_amisha
);

  localparam int W  = N * K;
  localparam int IW = idx_width(K);
  localparam logic [IW-1:0] IDX_LAST = IW'(K - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;

  logic [N-1:0]  slice_sum_s;
  logic          slice_cout_s;

  // The single shared datapath slice, fed from the slice selected by idx_q.
  adder_slice_cin_amisha #(.N(N)) u_slice (
    .a_i    (a_q[idx_q*N +: N]),
    .b_i    (b_q[idx_q*N +: N]),
    .cin_i  (carry_q),
    .sum_o  (slice_sum_s),
    .cout_o (slice_cout_s)
  );

  // Next-state, slice write-back and operand capture.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_amisha) begin
          // Accepted start: capture operands, seed carry, clear the result.
          a_d     = a_amisha;
          b_d     = b_amisha;
          carry_d = cin_amisha;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = ST_ADD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADD: begin
        sum_d[idx_q*N +: N] = slice_sum_s;
        carry_d             = slice_cout_s;
        if (idx_q == IDX_LAST) begin
          // Index saturates here; the next accepted start reloads it.
          cout_d  = slice_cout_s;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and result registers.
  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Status flags decoded directly from the state register.
  always_comb begin
    ready_amisha = 1'b0;
    busy_amisha  = 1'b0;
    done_amisha  = 1'b0;
    case (state_q)
      ST_IDLE: ready_amisha = 1'b1;
      ST_ADD:  busy_amisha  = 1'b1;
      ST_DONE: begin
        ready_amisha = 1'b1;
        done_amisha  = 1'b1;
      end
      default: ready_amisha = 1'b0;
    endcase
  end

  assign sum_amisha  = sum_q;
  assign cout_amisha = cout_q;

endmodule

// File: tb/tb_adder_seq_ctrl_amisha.sv
module tb_adder_seq_ctrl_amisha;

  localparam int N = 4;
  localparam int K = 4;
  localparam int W = N * K;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         cin_in;
  logic         ready, busy, done, cout;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  // Behavioural model: the full result of the last accepted op and how many
  // clock edges have passed since it was accepted.
  logic [W:0] m_full  = '0;
  int         m_cnt   = 0;
  bit         m_valid = 1'b0;

  adder_seq_ctrl_amisha #(.N(N), .K(K)) dut (
    .clk_amisha   (clk),
    .rst_n_amisha (rst_n),
    .start_amisha (start),
    .a_amisha     (a_in),
    .b_amisha     (b_in),
    .cin_amisha   (cin_in),
    .ready_amisha (ready),
    .busy_amisha  (busy),
    .done_amisha  (done),
    .sum_amisha   (sum),
    .cout_amisha  (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: a start is taken whenever no op is in flight.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_cnt   <= 0;
      m_full  <= '0;
    end else if ((!m_valid || m_cnt >= K) && start) begin
      m_full  <= (W+1)'(a_in) + (W+1)'(b_in) + (W+1)'(cin_in);
      m_cnt   <= 0;
      m_valid <= 1'b1;
    end else if (m_valid && m_cnt <= K) begin
      m_cnt   <= m_cnt + 1;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [W-1:0] msk;
    logic [W-1:0] e_sum;
    logic         e_cout, e_ready, e_busy, e_done;
    msk = '0;
    for (int i = 0; i < W; i++) if (i < m_cnt * N) msk[i] = 1'b1;
    if (!m_valid) begin
      e_sum = '0; e_cout = 1'b0; e_ready = 1'b1; e_busy = 1'b0; e_done = 1'b0;
    end else if (m_cnt < K) begin
      e_sum = m_full[W-1:0] & msk; e_cout = 1'b0;
      e_ready = 1'b0; e_busy = 1'b1; e_done = 1'b0;
    end else begin
      e_sum = m_full[W-1:0]; e_cout = m_full[W];
      e_ready = 1'b1; e_busy = 1'b0; e_done = (m_cnt == K);
    end
    chk("cyc_sum",   32'(sum),   32'(e_sum));
    chk("cyc_cout",  32'(cout),  32'(e_cout));
    chk("cyc_ready", 32'(ready), 32'(e_ready));
    chk("cyc_busy",  32'(busy),  32'(e_busy));
    chk("cyc_done",  32'(done),  32'(e_done));
  end

  // Present a start for one edge; 'now' means we are already at a negedge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input bit now);
    if (!now) @(negedge clk);
    #1;
    a_in = a; b_in = b; cin_in = c; start = 1'b1;
    @(negedge clk);
    acc_cyc = cyc;
    #1 start = 1'b0;
  endtask

  // Wait (bounded) for done and check the result plus latency from start.
  task automatic wait_done(input string name, input logic [W-1:0] es, input logic ec);
    bit got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no done expected done within 20 cycles", name);
    end else begin
      chk({name, "_lat"},  32'(cyc - acc_cyc + 1), 32'd5);
      chk({name, "_sum"},  32'(sum),  32'(es));
      chk({name, "_cout"}, 32'(cout), 32'(ec));
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   rfull;
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0;

    // 1: reset
    repeat (3) @(negedge clk);
    chk("rst_sum",   32'(sum),   32'h0);
    chk("rst_cout",  32'(cout),  32'h0);
    chk("rst_done",  32'(done),  32'h0);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_ready", 32'(ready), 32'h1);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_ready", 32'(ready), 32'h1);

    // 2: simple carry across a slice boundary
    start_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
    wait_done("t2", 16'h0100, 1'b0);
    @(negedge clk);
    chk("t2_done_once", 32'(done), 32'h0);

    // 3: carry ripples through every slice
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_done("t3", 16'h0000, 1'b1);

    // 4: carry-in only, then back-to-back start in the done cycle
    start_op(16'h0000, 16'h0000, 1'b1, 1'b0);
    wait_done("t4a", 16'h0001, 1'b0);
    start_op(16'h1234, 16'h4321, 1'b0, 1'b1);
    chk("t4_no_idle_busy", 32'(busy), 32'h1);
    wait_done("t4b", 16'h5555, 1'b0);

    // 5: start while busy is ignored
    start_op(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    @(negedge clk); #1;
    a_in = 16'hFFFF; b_in = 16'hFFFF; start = 1'b1;
    chk("t5_ready_busy", 32'(ready), 32'h0);
    @(negedge clk); #1 start = 1'b0;
    wait_done("t5", 16'h1010, 1'b0);

    // 6: reset mid-operation, then a clean op
    start_op(16'h8000, 16'h8000, 1'b0, 1'b0);
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    chk("t6_abort_sum",   32'(sum),   32'h0);
    chk("t6_abort_busy",  32'(busy),  32'h0);
    chk("t6_abort_ready", 32'(ready), 32'h1);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    start_op(16'h8000, 16'h8000, 1'b0, 1'b0);
    wait_done("t6", 16'h0000, 1'b1);

    // Randomized ops with input churn and ignored starts while busy
    for (int t = 0; t < 30; t++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      rfull = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc);
      start_op(ra, rb, rc, 1'b0);
      for (int j = 0; j < 2; j++) begin
        @(negedge clk); #1;
        a_in = W'($urandom); b_in = W'($urandom);
        cin_in = 1'($urandom); start = 1'($urandom);
      end
      @(negedge clk); #1 start = 1'b0;
      wait_done("rnd", rfull[W-1:0], rfull[W]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_seq_ctrl_amisha.md
Name: adder_seq_ctrl_amisha

Overview:
Multi-cycle sequencer that adds two W-bit operands using one shared N-bit adder slice, processing one slice per clock from LSB to MSB. Carry between slices is held in a register. The block accepts a start/ready handshake and reports completion with a one-cycle done pulse. It sits in front of the parameterized carry adder datapath so that wide additions can be done without a W-bit ripple adder.

Parameters:
N, 4, slice width in bits (width of the shared adder)
K, 4, number of slices per operation; K >= 2
W, N*K, operand/result width (derived; not overridable)

Ports:
clk_amisha  input  1  clock, rising-edge
rst_n_amisha  input  1  asynchronous active-low reset
start_amisha  input  1  request a new addition; sampled only when ready_amisha=1
a_amisha  input  W  operand A; captured on accepted start
b_amisha  input  W  operand B; captured on accepted start
cin_amisha  input  1  carry-in to slice 0; captured on accepted start
ready_amisha  output  1  block can accept start this cycle
busy_amisha  output  1  operation in progress
done_amisha  output  1  one-cycle pulse: result valid
sum_amisha  output  W  result; held stable from done until the next accepted start
cout_amisha  output  1  carry out of slice K-1; held with sum

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset (async assert, rst_n_amisha=0): state=IDLE, slice index=0, carry reg=0, operand regs=0, sum=0, cout=0, done=0, busy=0, ready=1.
- FSM states and transitions:
  - IDLE -> ADD on start.
  - ADD -> ADD while idx<K-1.
  - ADD -> DONE when idx=K-1.
  - DONE -> ADD on start.
  - DONE -> IDLE otherwise.
- ready=1 in IDLE and DONE. busy=1 only in ADD. done=1 only in DONE.
- Accepted start (ready=1 and start=1) does all of the following:
  - Latch a, b, cin (cin goes into the carry reg).
  - Set idx=0.
  - Clear sum and cout to 0.
- ADD cycle i:
  - Slice adder computes a_reg[iN+N-1:iN] + b_reg[iN+N-1:iN] + carry.
  - The N-bit result is written to sum[iN+N-1:iN]. The slice carry-out goes to the carry reg.
  - idx increments.
  - On i=K-1 the slice carry-out is also written to cout.
- Latency:
  - Start accepted at edge t. Slices are written on edges t+1 … t+K.
  - done is high in the cycle after edge t+K, i.e. K+1 cycles after start.
  - Throughput is one op per K+1 cycles. A start during DONE gives back-to-back operation with no IDLE cycle.
- start while busy=1 is ignored. Operands are not relatched and the op in flight is unaffected.
- Input a/b/cin changes after acceptance have no effect.
- sum is only guaranteed valid while done=1 or in the IDLE state that follows. In ADD it holds a partial result: lower slices are final, upper slices are 0.
- Arithmetic is modulo 2^W; overflow is reported only via cout. All-ones plus 1 ripples the carry through every slice.
- Reset mid-operation: immediate abort to the reset values. No done pulse for the aborted op. The first start after reset release is accepted normally.
- The idx counter never exceeds K-1. No wrap-around occurs inside an op.

Decomposition:
- Shared package adder_seq_pkg_amisha holds:
  - FSM state encoding: IDLE=2'b00, ADD=2'b01, DONE=2'b10; 2'b11 recovers to IDLE.
  - The function/constant for idx width, clog2(K) with a minimum of 1.
- Sub-module adder_slice_cin_amisha (parameter N): combinational N-bit add with carry-in and carry-out. It is the single shared datapath resource, instantiated once.
- The controller holds the FSM, idx counter, carry reg, operand regs and slice write-enable/muxing.

Test Plan (N=4, K=4, W=16):
1. Hold rst_n=0 for 3 cycles, then release. Expect sum=16'h0000, cout=0, done=0, busy=0, ready=1 throughout and after release.
2. a=16'h00FF, b=16'h0001, cin=0, pulse start. Expect busy=1 for 4 cycles, then done=1 for exactly 1 cycle with sum=16'h0100, cout=0. done lands 5 cycles after start.
3. a=16'hFFFF, b=16'h0001, cin=0. Expect sum=16'h0000, cout=1. Mid-op sum checkpoints after each slice: 16'h0000 with carry propagating every cycle.
4. a=16'h0000, b=16'h0000, cin=1. Expect sum=16'h0001, cout=0. Then, in the DONE cycle, start again with a=16'h1234, b=16'h4321, cin=0. Expect no IDLE gap, the next done 5 cycles later, sum=16'h5555.
5. Start with a=16'h0F0F, b=16'h0101, then assert start with a=16'hFFFF, b=16'hFFFF on ADD cycle 2. The second start is ignored. Expect sum=16'h1010, cout=0, and ready=0 until DONE.
6. Start a=16'h8000, b=16'h8000, then drop rst_n during ADD cycle 2. Expect immediate sum=0, busy=0, ready=1, and no done pulse. After release, start a=16'h8000, b=16'h8000. Expect sum=16'h0000, cout=1.
